// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 8x8 signed MAC: clears the accumulator, streams operand pairs from the
// buffers, counts returned valids and holds the dot product on a valid/ready port.
// Optional watchdog on the result wait: define MAC_CTRL_TIMEOUT_EN.
module mac_seq_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int RES_SKEW    = 1,
  parameter int CLR_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   vec_len_i,
  output logic [ADDR_W-1:0] ibuf_addr_o,
  output logic [ADDR_W-1:0] wbuf_addr_o,
  output logic              buf_rd_o,
  input  logic [7:0]        ibuf_data_i,
  input  logic [7:0]        wbuf_data_i,
  output logic              mac_rstn_o,
  output logic              mac_enable_o,
  output logic              mac_valid_o,
  output logic [7:0]        mac_input_o,
  output logic [7:0]        mac_weight_o,
  input  logic              mac_valid_i,
  input  logic [31:0]       mac_result_i,
  output logic [31:0]       result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [2:0]        dbg_state_o
);

  // Result port: result_o is held stable while result_valid_o is high; the transfer
  // happens on a clock edge where result_valid_o and result_ready_i are both high.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rx_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_clr_cnt;
  logic              r_rd_q;
  logic              r_got_last;

  logic [ADDR_W:0]   w_addr_inc;
  logic              w_fetch_last;
  logic              w_last_pulse;
  logic              w_capture;
  logic              w_timeout;

  assign w_addr_inc   = {1'b0, r_addr} + (ADDR_W+1)'(1);
  assign w_fetch_last = (w_addr_inc == r_len);
  assign w_last_pulse = mac_valid_i && ((r_rx_cnt + (ADDR_W+1)'(1)) == r_len);
  // With zero skew the final result sits on the bus alongside the last valid.
  assign w_capture    = (RES_SKEW == 0) ? w_last_pulse : r_got_last;

  assign ibuf_addr_o  = r_addr;
  assign wbuf_addr_o  = r_addr;
  assign mac_valid_o  = r_rd_q;
  assign mac_input_o  = r_rd_q ? ibuf_data_i : 8'd0;
  assign mac_weight_o = r_rd_q ? wbuf_data_i : 8'd0;
  assign busy_o       = (r_state != S_IDLE);
  assign dbg_state_o  = r_state;

`ifdef MAC_CTRL_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_error;

  assign w_timeout = !mac_valid_i && (r_wd == 16'(TIMEOUT_CYC - 1));
  assign error_o   = r_error;

  // Counts WAIT cycles since the last returned valid; restarts on every WAIT entry.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wd    <= 16'd0;
      r_error <= 1'b0;
    end else begin
      if (r_state != S_WAIT || mac_valid_i) r_wd <= 16'd0;
      else                                  r_wd <= r_wd + 16'd1;
      if (r_state == S_WAIT && !w_capture && w_timeout) r_error <= 1'b1;
      else if (r_state == S_OUT && result_ready_i)      r_error <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_rx_cnt       <= '0;
      r_addr         <= '0;
      r_clr_cnt      <= 8'd0;
      r_rd_q         <= 1'b0;
      r_got_last     <= 1'b0;
      buf_rd_o       <= 1'b0;
      mac_rstn_o     <= 1'b1;
      mac_enable_o   <= 1'b0;
      result_o       <= 32'd0;
      result_valid_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      r_rd_q <= buf_rd_o;
      if ((r_state == S_FETCH || r_state == S_WAIT) && mac_valid_i) begin
        r_rx_cnt <= r_rx_cnt + (ADDR_W+1)'(1);
        if (w_last_pulse) r_got_last <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len      <= vec_len_i;
            r_rx_cnt   <= '0;
            r_got_last <= 1'b0;
            r_addr     <= '0;
            r_clr_cnt  <= 8'd0;
            result_o   <= 32'd0;
            if (vec_len_i == '0) begin
              r_state        <= S_OUT;
              result_valid_o <= 1'b1;
            end else begin
              r_state    <= S_CLEAR;
              mac_rstn_o <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == 8'(CLR_CYC - 1)) begin
            r_state      <= S_FETCH;
            mac_rstn_o   <= 1'b1;
            buf_rd_o     <= 1'b1;
            mac_enable_o <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 8'd1;
          end
        end
        S_FETCH: begin
          // Comparing the 1-wider increment lets LEN = 2**ADDR_W finish before the wrap.
          if (w_fetch_last) begin
            r_addr   <= '0;
            buf_rd_o <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_addr <= w_addr_inc[ADDR_W-1:0];
          end
        end
        S_WAIT: begin
          if (w_capture) begin
            result_o       <= mac_result_i;
            result_valid_o <= 1'b1;
            mac_enable_o   <= 1'b0;
            r_state        <= S_OUT;
          end else if (w_timeout) begin
            result_o       <= 32'd0;
            result_valid_o <= 1'b1;
            mac_enable_o   <= 1'b0;
            r_state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            done_o         <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
